// File: rtl/sqw_pkg.sv
// Shared types and widths for the square-wave period/high-time meter.
//   CNT_W         width of the period/high-time counters and result fields
//   meas_state_t  edge-sequencing FSM states
//   meas_res_t    one published measurement {period, high}
//   sat_inc       increment that holds at all-ones instead of wrapping
package sqw_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } meas_state_t;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
  } meas_res_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/square_wave_meter_if.sv
// Result port of the square-wave meter: valid/ready with period and high time.
//   res_valid   result held on res_period/res_high
//   res_ready   consumer accepts when res_valid && res_ready
//   res_period  clk cycles between consecutive rising edges
//   res_high    clk cycles the input was high within that period
interface square_wave_meter_if;
  import sqw_pkg::*;

  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_period;
  logic [CNT_W-1:0] res_high;

  modport master (output res_valid, output res_period, output res_high, input res_ready);
  modport slave  (input res_valid, input res_period, input res_high, output res_ready);

endinterface

// File: rtl/sqw_sync_edge.sv
// Synchronises an asynchronous input and flags its rising/falling edges.
//   clk, rst_n  clock and asynchronous active-low reset
//   d_async     asynchronous input
//   level       synchronised level
//   rise, fall  registered one-cycle edge pulses, SYNC_STAGES+1 cycles after the pin
module sqw_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  // Synchroniser chain, delayed copy and registered edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
      s_d    <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~s_d;
      fall   <= ~sync_q[SYNC_STAGES-1] & s_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/square_wave_meter.sv
// Measures period and high time of an asynchronous square wave in clk cycles,
// one result per input period, presented on a valid/ready port.
//   clk, rst_n   clock, asynchronous active-low reset
//   sig_in       asynchronous square wave under measurement
//   res          result port (square_wave_meter_if.master)
//   overrun      sticky: a result was dropped while the previous one was pending
//   no_signal    no sig_in edge for TIMEOUT cycles; cleared by the next rise
//   clr_overrun  single-cycle pulse clearing overrun (a coincident drop wins)
// Build option: define DUTY_EN to implement the high-time counter; otherwise
// res_high is always 0.
module square_wave_meter
  import sqw_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sig_in,
  square_wave_meter_if.master res,
  output logic                overrun,
  output logic                no_signal,
  input  logic                clr_overrun
);

  localparam logic [CNT_W-1:0] TOUT_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TOUT_M1  = CNT_W'(TIMEOUT - 1);

  logic             rise, fall, any_edge;
  logic             level_unused;
  meas_state_t      state_q, state_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic             no_sig_d;
  logic             publish;
  meas_res_t        new_res, res_q;
  logic             valid_q;
`ifdef DUTY_EN
  logic [CNT_W-1:0] hi_q, hi_d;
`endif

  sqw_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_async (sig_in),
    .level   (level_unused),
    .rise    (rise),
    .fall    (fall)
  );

  assign any_edge = rise | fall;

  // Measurement state and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      per_q     <= '0;
      idle_q    <= '0;
      no_signal <= 1'b0;
`ifdef DUTY_EN
      hi_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      idle_q    <= idle_d;
      no_signal <= no_sig_d;
`ifdef DUTY_EN
      hi_q      <= hi_d;
`endif
    end
  end

  // Edge sequencing, timeout and result generation.
  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    idle_d   = idle_q;
    no_sig_d = no_signal;
    publish  = 1'b0;
    new_res  = '0;
`ifdef DUTY_EN
    hi_d     = hi_q;
`endif

    // idle_cnt parks at TIMEOUT so the timeout fires once per silence.
    if (any_edge) begin
      idle_d = '0;
    end else if (idle_q != TOUT_MAX) begin
      idle_d = idle_q + CNT_W'(1);
    end

    if (!any_edge && (idle_q == TOUT_M1)) begin
      no_sig_d = 1'b1;
      state_d  = IDLE;
      per_d    = '0;
`ifdef DUTY_EN
      hi_d     = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = HIGH;
            per_d   = '0;
`ifdef DUTY_EN
            hi_d    = '0;
`endif
          end
        end
        HIGH: begin
          per_d = sat_inc(per_q);
`ifdef DUTY_EN
          hi_d  = sat_inc(hi_q);
`endif
          if (fall) state_d = LOW;
        end
        LOW: begin
          if (rise) begin
            // The rise cycle itself closes the period, hence the +1.
            publish        = 1'b1;
            new_res.period = sat_inc(per_q);
`ifdef DUTY_EN
            new_res.high   = hi_q;
            hi_d           = '0;
`endif
            per_d          = '0;
            state_d        = HIGH;
          end else begin
            per_d = sat_inc(per_q);
          end
        end
        default: state_d = IDLE;
      endcase
      if (rise) no_sig_d = 1'b0;
    end
  end

  // Output register: load when empty or being drained, else drop and flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      overrun <= 1'b0;
    end else begin
      if (publish && (!valid_q || res.res_ready)) begin
        res_q   <= new_res;
        valid_q <= 1'b1;
      end else if (valid_q && res.res_ready) begin
        valid_q <= 1'b0;
      end
      if (publish && valid_q && !res.res_ready) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

  assign res.res_valid  = valid_q;
  assign res.res_period = res_q.period;
  assign res.res_high   = res_q.high;

endmodule

// File: tb/tb_square_wave_meter.sv
// Self-checking bench for square_wave_meter: an event-level reference model
// (edge times sampled at posedge, results derived from sample-index differences)
// compared every cycle, plus literal expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_square_wave_meter;
  import sqw_pkg::*;

  localparam int unsigned TOUT = 200;
  localparam int          LAT  = 3;   // pin sample -> FSM action, in clk cycles
`ifdef DUTY_EN
  localparam int HI25 = 2;
  localparam int HI9_LO = 5;
  localparam int HI9_HI = 6;
`else
  localparam int HI25 = 0;
  localparam int HI9_LO = 0;
  localparam int HI9_HI = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sig_in = 1'b0;
  logic clr_overrun = 1'b0;
  logic overrun, no_signal;

  square_wave_meter_if res_if();

  square_wave_meter #(.SYNC_STAGES(2), .TIMEOUT(TOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sig_in      (sig_in),
    .res         (res_if),
    .overrun     (overrun),
    .no_signal   (no_signal),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0d, want %0d", nm, got, want);
  endtask

  task automatic chk_rng(input string nm, input int got, input int lo, input int hi);
    checks++;
    if (got >= lo && got <= hi) passes++;
    else $display("FAIL %s: got %0d, want %0d..%0d", nm, got, lo, hi);
  endtask

  // ---------------- reference model ----------------
  typedef struct {int act; bit rise; int smp;} ev_t;
  ev_t pend[$];
  int  cyc = 0;
  bit  prev_smp, armed;
  int  rise_smp, fall_smp, last_act;
  bit  m_valid, m_ovr, m_nosig;
  int  m_per, m_high;

  always @(posedge clk) begin
    ev_t e;
    bit  pub, set_ovr, acc;
    int  p_per, p_hi;
    cyc++;
    if (!rst_n) begin
      pend.delete();
      prev_smp = 1'b0; armed = 1'b0; last_act = cyc;
      m_valid = 1'b0; m_per = 0; m_high = 0; m_ovr = 1'b0; m_nosig = 1'b0;
    end else begin
      pub = 1'b0; p_per = 0; p_hi = 0; set_ovr = 1'b0;
      if (pend.size() > 0 && pend[0].act == cyc) begin
        e = pend.pop_front();
        last_act = cyc;
        if (e.rise) begin
          if (armed) begin
            pub = 1'b1;
            p_per = e.smp - rise_smp;
            p_hi = fall_smp - rise_smp;
          end
          armed = 1'b1; rise_smp = e.smp; m_nosig = 1'b0;
        end else begin
          fall_smp = e.smp;
        end
      end else if (cyc - last_act == int'(TOUT)) begin
        m_nosig = 1'b1; armed = 1'b0;
      end
      acc = m_valid && res_if.res_ready;
      if (pub) begin
        if (!m_valid || acc) begin
          m_valid = 1'b1; m_per = p_per;
`ifdef DUTY_EN
          m_high = p_hi;
`else
          m_high = 0;
`endif
        end else set_ovr = 1'b1;
      end else if (acc) m_valid = 1'b0;
      if (set_ovr) m_ovr = 1'b1;
      else if (clr_overrun) m_ovr = 1'b0;
      if (sig_in != prev_smp) begin
        pend.push_back('{cyc + LAT, sig_in, cyc});
        prev_smp = sig_in;
      end
    end
  end

  // ---------------- per-cycle compare + accepted-result checks ----------------
  int phase = 0;
  int acc_n = 0;
  int sum9 = 0;
  int n9 = 0;

  always @(negedge clk) begin
    bit ev, eo, en;
    int ep, eh;
    if (!rst_n) begin
      ev = 0; ep = 0; eh = 0; eo = 0; en = 0;
    end else begin
      ev = m_valid; ep = m_per; eh = m_high; eo = m_ovr; en = m_nosig;
    end
    checks++;
    if (res_if.res_valid === ev && res_if.res_period === CNT_W'(ep) &&
        res_if.res_high === CNT_W'(eh) && overrun === eo && no_signal === en)
      passes++;
    else
      $display("FAIL cycle %0d: valid/period/high/overrun/no_signal got %b/%0d/%0d/%b/%b want %b/%0d/%0d/%b/%b",
               cyc, res_if.res_valid, res_if.res_period, res_if.res_high, overrun, no_signal,
               ev, ep, eh, eo, en);
    if (rst_n && res_if.res_valid && res_if.res_ready && phase != 0) begin
      acc_n++;
      if (acc_n > 2) begin
        if (phase == 1) begin
          chk("p25_period", int'(res_if.res_period), 4);
          chk("p25_high", int'(res_if.res_high), HI25);
        end else if (phase == 2) begin
          chk_rng("p9_period", int'(res_if.res_period), 11, 12);
          chk_rng("p9_high", int'(res_if.res_high), HI9_LO, HI9_HI);
          if (n9 < 100) begin
            sum9 += int'(res_if.res_period);
            n9++;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  real hi_ns = 20.0, lo_ns = 20.0, rem = 10.0;
  bit  lvl = 1'b0, hold = 1'b0, rnd = 1'b0, rnd_hs = 1'b0;

  task automatic pick_half(output real h);
    if ($urandom_range(0, 19) == 0) h = real'($urandom_range(2100, 2500));
    else h = real'($urandom_range(15, 400));
  endtask

  // One clk cycle; inputs change 3 ns after posedge, well clear of both edges.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #3;
      if (hold) begin
        sig_in = 1'b0;
      end else begin
        rem -= 10.0;
        while (rem <= 0.0) begin
          lvl = !lvl;
          if (rnd) begin
            pick_half(hi_ns);
            pick_half(lo_ns);
          end
          rem += lvl ? hi_ns : lo_ns;
        end
        sig_in = lvl;
      end
      if (rnd_hs) begin
        res_if.res_ready = ($urandom_range(0, 3) != 0);
        clr_overrun = ($urandom_range(0, 15) == 0);
      end
    end
  endtask

  initial begin
    bit prev, found;
    int pr;
    res_if.res_ready = 1'b1;
    step(2);
    #1;
    chk("reset_valid", int'(res_if.res_valid), 0);
    chk("reset_period", int'(res_if.res_period), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_no_signal", int'(no_signal), 0);
    rst_n = 1'b1;

    // 25 MHz, always ready
    rem = real'($urandom_range(1, 20));
    phase = 1; acc_n = 0;
    step(60);
    phase = 0;

    // consumer stalls for three input periods
    res_if.res_ready = 1'b0;
    step(12);
    chk("stall_valid", int'(res_if.res_valid), 1);
    chk("stall_period", int'(res_if.res_period), 4);
    chk("stall_high", int'(res_if.res_high), HI25);
    chk("stall_overrun", int'(overrun), 1);
    res_if.res_ready = 1'b1;
    clr_overrun = 1'b1;
    step(1);
    clr_overrun = 1'b0;
    chk("clr_overrun", int'(overrun), 0);
    step(8);

    // 9 MHz
    hi_ns = 55.555; lo_ns = 55.555;
    phase = 2; acc_n = 0;
    step(1300);
    phase = 0;
    chk("p9_count", n9, 100);
    chk_rng("p9_sum100", sum9, 1110, 1112);

    // 25 MHz then held low: timeout
    hi_ns = 20.0; lo_ns = 20.0; rem = 5.0;
    step(20);
    prev = sig_in; found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1);
      if (prev && !sig_in) found = 1'b1;
      prev = sig_in;
    end
    chk("t4_fall_found", int'(found), 1);
    hold = 1'b1;
    step(203);
    chk("t4_before_timeout", int'(no_signal), 0);
    step(1);
    chk("t4_at_timeout", int'(no_signal), 1);
    step(20);
    hold = 1'b0; lvl = 1'b0; rem = 0.0;
    step(1);
    step(3);
    chk("t4_still_no_signal", int'(no_signal), 1);
    step(1);
    chk("t4_rise_clears", int'(no_signal), 0);
    chk("t4_no_partial_result", int'(res_if.res_valid), 0);

    // reset mid-HIGH on a 100 ns / 100 ns wave
    hi_ns = 100.0; lo_ns = 100.0;
    step(30);
    prev = sig_in; found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1);
      if (sig_in && !prev) found = 1'b1;
      prev = sig_in;
    end
    chk("t5_rise_found", int'(found), 1);
    step(5);
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", int'(res_if.res_valid), 0);
    chk("t5_async_period", int'(res_if.res_period), 0);
    chk("t5_async_no_signal", int'(no_signal), 0);
    step(3);
    rst_n = 1'b1;
    // synchroniser restarts from 0, so a high pin counts as a rise
    prev = 1'b0; pr = 0; found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      step(1);
      if (sig_in && !prev) pr++;
      prev = sig_in;
      if (res_if.res_valid) found = 1'b1;
    end
    chk("t5_result_seen", int'(found), 1);
    chk("t5_rises_before_result", pr, 2);

    // randomized waveform, handshake and clears
    rnd = 1'b1; rnd_hs = 1'b1;
    step(4000);
    rnd = 1'b0; rnd_hs = 1'b0;
    res_if.res_ready = 1'b1; clr_overrun = 1'b0;
    step(5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
